// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared types and widths for the LC3 memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational round-robin / burst-limited grant decision.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import lc3_mem_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  arb_state_t       state,
  input  port_id_t         last_gnt,
  input  logic [CNT_W-1:0] burst_cnt,
  input  logic             c_req,
  input  logic             d_req,
  output logic             gnt_c,
  output logic             gnt_d
);

  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  logic at_limit;
  assign at_limit = (burst_cnt >= BURST_LIMIT);

  // Owner keeps the bus until it drops its request or the other port has waited a full burst
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    case (state)
      IDLE: begin
        if (c_req && d_req) begin
          if (last_gnt == PORT_D) gnt_c = 1'b1;
          else                    gnt_d = 1'b1;
        end else begin
          gnt_c = c_req;
          gnt_d = d_req;
        end
      end
      OWN_C: begin
        if (c_req && !(d_req && at_limit)) gnt_c = 1'b1;
        else if (d_req)                    gnt_d = 1'b1;
      end
      OWN_D: begin
        if (d_req && !(c_req && at_limit)) gnt_d = 1'b1;
        else if (c_req)                    gnt_c = 1'b1;
      end
      default: begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (CPU / debug) arbiter in front of a 1-cycle RAM.
//               Owner FSM, burst counter and read-return tag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t        state;
  port_id_t          last_gnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic              run;
  logic              pick_c;
  logic              pick_d;
  logic              gnt_c;
  logic              gnt_d;
  logic              rtag_vld;
  port_id_t          rtag_port;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  mem_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .state     (state),
    .last_gnt  (last_gnt),
    .burst_cnt (burst_cnt),
    .c_req     (c_req),
    .d_req     (d_req),
    .gnt_c     (pick_c),
    .gnt_d     (pick_d)
  );

  // run drops asynchronously with reset so no grant can leak out while rst_n is low
  assign gnt_c = pick_c & run;
  assign gnt_d = pick_d & run;

  // Enable flag: cleared by reset, set on the first clock edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Owner FSM with round-robin memory and saturating burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= PORT_D;
      burst_cnt <= '0;
    end else if (gnt_c) begin
      state     <= OWN_C;
      last_gnt  <= PORT_C;
      if (state == OWN_C) burst_cnt <= (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_ONE;
      else                burst_cnt <= CNT_ONE;
    end else if (gnt_d) begin
      state     <= OWN_D;
      last_gnt  <= PORT_D;
      if (state == OWN_D) burst_cnt <= (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_ONE;
      else                burst_cnt <= CNT_ONE;
    end else begin
      state <= IDLE;
    end
  end

  // Return tag: remembers which port issued the read being answered this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtag_vld  <= 1'b0;
      rtag_port <= PORT_C;
    end else begin
      rtag_vld  <= (gnt_c & ~c_we) | (gnt_d & ~d_we);
      rtag_port <= gnt_d ? PORT_D : PORT_C;
    end
  end

  assign c_rvalid = rtag_vld && (rtag_port == PORT_C);
  assign d_rvalid = rtag_vld && (rtag_port == PORT_D);

  // Capture returned data so rdata holds its last value between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (c_rvalid) c_rdata_q <= mem_data;
      if (d_rvalid) d_rdata_q <= mem_data;
    end
  end

  assign c_rdata = c_rvalid ? mem_data : c_rdata_q;
  assign d_rdata = d_rvalid ? mem_data : d_rdata_q;
  assign c_gnt   = gnt_c;
  assign d_gnt   = gnt_d;

  // RAM command mux: granted port's request, all-zero when nobody is granted
  always_comb begin
    mem_en   = gnt_c | gnt_d;
    we       = 1'b0;
    mem_addr = '0;
    ram_data = '0;
    if (gnt_c) begin
      we       = c_we;
      mem_addr = c_addr;
      ram_data = c_wdata;
    end else if (gnt_d) begin
      we       = d_we;
      mem_addr = d_addr;
      ram_data = d_wdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one owner while the other port is requesting.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports c_req, c_we, input, 1 each: CPU access request and write-enable.
REQ-005 SHALL have ports c_addr, c_wdata, input, 16 each: CPU address and write data.
REQ-006 SHALL have ports c_gnt, c_rvalid, output, 1 each, and c_rdata, output, 16: CPU grant, read-valid and read data.
REQ-007 SHALL have ports d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, with the same directions and widths as the c_* ports: debug/loader port.
REQ-008 SHALL have ports mem_en, output, 1; we, output, 1; mem_addr, output, 16; ram_data, output, 16: RAM enable, write-enable, address and write data.
REQ-009 SHALL have port mem_data, input, 16: RAM read data, valid one cycle after a read is enabled.

Function
REQ-010 SHALL grant at most one port per cycle; a grant is combinational from the current requests plus the registered state.
REQ-011 SHALL implement states IDLE, OWN_C and OWN_D, with transitions on the rising clock edge.
REQ-012 IDLE, single request: SHALL grant the requester in the same cycle and move to that requester's OWN state.
REQ-013 IDLE, both requesting: SHALL grant the port not recorded in last_gnt (round-robin).
REQ-014 OWN_x, x_req=1, other port idle: SHALL keep granting x with no burst limit.
REQ-015 OWN_x, x_req=1, other port requesting: SHALL keep granting x only while burst_cnt < MAX_BURST; otherwise SHALL grant the other port that cycle and switch state.
REQ-016 OWN_x, x_req=0: SHALL grant the other port if it is requesting, otherwise go to IDLE with no grant.
REQ-017 burst_cnt SHALL reset to 1 on every owner change, increment on each consecutive grant to the same owner, and saturate at MAX_BURST.
REQ-018 last_gnt SHALL update to the granted port on every grant.
REQ-019 Granted cycle: mem_en=1, and we, mem_addr and ram_data SHALL equal the granted port's we, addr and wdata; with no grant, mem_en=0, we=0, mem_addr=0 and ram_data=0.
REQ-020 A granted read (we=0) SHALL assert that port's rvalid for exactly one cycle on the next cycle, with rdata = mem_data.
REQ-021 rdata SHALL hold its last value when rvalid=0.
REQ-022 A granted write SHALL produce no rvalid.
REQ-023 Back-to-back reads SHALL give one rvalid per cycle, with no bubble at an owner switch; the return tag SHALL be registered per access.

Reset
REQ-024 rst_n=0 SHALL force, asynchronously: state=IDLE, last_gnt=D (CPU wins the first tie), burst_cnt=0, and the return tag cleared.
REQ-025 During reset all outputs SHALL be 0, including c_rdata and d_rdata.
REQ-026 A read granted in the cycle reset asserts SHALL NOT produce rvalid after reset releases.

Structure
REQ-027 Package lc3_mem_pkg SHALL hold: arb_state_t (IDLE, OWN_C, OWN_D), port_id_t (PORT_C, PORT_D), DATA_W=16 and ADDR_W=16.
REQ-028 The round-robin/burst grant decision SHALL be one combinational sub-module, mem_arb_pick; the FSM, counters and return tag SHALL live in mem_arbiter.
REQ-029 The bench SHALL model the RAM with a 1-cycle synchronous read, matching the LC3 RAM.

Verification
REQ-030 Only c_req=1, c_we=0, c_addr=0x3000, with RAM[0x3000]=0x1234 -> c_gnt same cycle; mem_addr=0x3000; next cycle c_rvalid=1 and c_rdata=0x1234; d_gnt=0 throughout.
REQ-031 Out of reset, c_req and d_req asserted together -> c_gnt first; next tie after CPU releases -> d_gnt.
REQ-032 MAX_BURST=4, d_req held and c_req held -> d gets exactly 4 consecutive grants, then c_gnt; alternating 4-beat bursts thereafter.
REQ-033 d write 0xBEEF to 0x0010, then c read of 0x0010 on the next cycle -> we=1 in cycle 1; c_rdata=0xBEEF in cycle 3; no d_rvalid.
REQ-034 rst_n pulsed low mid-read -> outputs 0 immediately; no rvalid after release; state IDLE.
REQ-035 Random requests over 1000 cycles -> never c_gnt and d_gnt both 1; every granted read returns exactly one rvalid to the correct port.
